i_debounce: RTL

Per-bit input debouncer with edge detection. It sits directly downstream of the two-flop input synchronizer and consumes its already-synchronized output. Each bit is accepted as a new level only after it has differed from the current debounced level for TH consecutive prescaler ticks. The block then produces the stable level plus one-clock rise/fall pulses for the joystick, mouse-button and switch logic.

---
 rtl/i_debounce.sv | 98 +++++++++
 1 files changed

// File: rtl/i_debounce.sv
// ----------------------------------------------------------------------------
// i_debounce
// Per-bit input debouncer with rise/fall edge pulses. Consumes the output of
// the two-flop input synchronizer. A bit takes a new level only after it has
// disagreed with the current debounced level for TH consecutive prescaler
// ticks. A shared prescaler issues one tick every DIV clk cycles.
//
// Parameters
//   DW   number of independent input bits
//   RS   reset/power-up level of every debounced bit
//   DIV  prescaler period in clk cycles (>= 1)
//   TH   consecutive mismatched ticks needed to accept a new level (>= 1)
//
// Ports
//   clk   in   1   system clock, rising edge
//   rst   in   1   synchronous active-high reset
//   i     in   DW  synchronized inputs
//   o     out  DW  debounced level (registered)
//   rise  out  DW  one-clock pulse when o[b] goes 0->1 (registered)
//   fall  out  DW  one-clock pulse when o[b] goes 1->0 (registered)
// ----------------------------------------------------------------------------
module i_debounce #(
    parameter int unsigned DW  = 1,
    parameter logic        RS  = 1'b0,
    parameter int unsigned DIV = 1024,
    parameter int unsigned TH  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i,
    output logic [DW-1:0] o,
    output logic [DW-1:0] rise,
    output logic [DW-1:0] fall
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW = (TH  > 1) ? $clog2(TH)  : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TH - 1);

    logic [PW-1:0]         pre_q, pre_d;
    logic                  tick;
    logic [DW-1:0][CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]         o_q, o_d;
    logic [DW-1:0]         rise_q, rise_d;
    logic [DW-1:0]         fall_q, fall_d;

    // Explicit wrap so non-power-of-two DIV counts 0..DIV-1; with DIV=1 the
    // counter sits at 0 and tick is permanently true.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_comb begin
        cnt_d  = cnt_q;
        o_d    = o_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned b = 0; b < DW; b++) begin
            if (i[b] == o_q[b]) begin
                // Any return to the current level discards the partial count.
                cnt_d[b] = '0;
            end else if (tick) begin
                if (cnt_q[b] == CNT_LAST) begin
                    o_d[b]    = i[b];
                    cnt_d[b]  = '0;
                    rise_d[b] = i[b];
                    fall_d[b] = ~i[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            o_q    <= {DW{RS}};
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o    = o_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule
